// File: rtl/operand_collector.sv
// Calculator front end: collects two packed-BCD operands and an operator from
// a stream of ASCII key codes, then signals the calculate stage to start.
module operand_collector #(
  parameter int         DIGITS  = 3,
  parameter logic [7:0] KEY_CLR = 8'h78
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  output logic [4*DIGITS-1:0]   reg_num1,
  output logic [4*DIGITS-1:0]   reg_num2,
  output logic [7:0]            sym,
  output logic [1:0]            cnt1,
  output logic [1:0]            cnt2,
  output logic                  calc_start,
  output logic                  err,
  output logic [1:0]            state
);

  localparam int         W       = 4 * DIGITS;
  localparam logic [1:0] CNT_MAX = 2'(DIGITS);

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_NUM2 = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_n;
  logic [W-1:0]   num1_n, num2_n;
  logic [7:0]     sym_n;
  logic [1:0]     cnt1_n, cnt2_n;
  logic           start_n, err_n;
  logic           is_digit, is_op, is_eq;

  assign is_digit = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign is_op    = (key_code >= 8'h61) && (key_code <= 8'h64);
  assign is_eq    = (key_code == 8'h65);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NUM1;
      reg_num1   <= '0;
      reg_num2   <= '0;
      sym        <= 8'h00;
      cnt1       <= 2'd0;
      cnt2       <= 2'd0;
      calc_start <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_n;
      reg_num1   <= num1_n;
      reg_num2   <= num2_n;
      sym        <= sym_n;
      cnt1       <= cnt1_n;
      cnt2       <= cnt2_n;
      calc_start <= start_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    num1_n  = reg_num1;
    num2_n  = reg_num2;
    sym_n   = sym;
    cnt1_n  = cnt1;
    cnt2_n  = cnt2;
    start_n = 1'b0;
    err_n   = 1'b0;

    if (key_valid) begin
      // Clear wins over every other interpretation of the key, in any state.
      if (key_code == KEY_CLR) begin
        state_n = S_NUM1;
        num1_n  = '0;
        num2_n  = '0;
        sym_n   = 8'h00;
        cnt1_n  = 2'd0;
        cnt2_n  = 2'd0;
      end else begin
        unique case (state_q)
          S_NUM1: begin
            if (is_digit) begin
              if (cnt1 < CNT_MAX) begin
                num1_n = {reg_num1[W-5:0], key_code[3:0]};
                cnt1_n = cnt1 + 2'd1;
              end else begin
                err_n = 1'b1;
              end
            end else if (is_op && cnt1 != 2'd0) begin
              sym_n   = key_code;
              state_n = S_NUM2;
            end else begin
              err_n = 1'b1;
            end
          end
          S_NUM2: begin
            if (is_digit) begin
              if (cnt2 < CNT_MAX) begin
                num2_n = {reg_num2[W-5:0], key_code[3:0]};
                cnt2_n = cnt2 + 2'd1;
              end else begin
                err_n = 1'b1;
              end
            end else if (is_op && cnt2 == 2'd0) begin
              // Operator can still be changed until the second operand starts.
              sym_n = key_code;
            end else if (is_eq && cnt2 != 2'd0 &&
                         !(sym == 8'h64 && reg_num2 == '0)) begin
              state_n = S_DONE;
              start_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          S_DONE: begin
            if (is_digit) begin
              num1_n  = {{(W-4){1'b0}}, key_code[3:0]};
              num2_n  = '0;
              cnt1_n  = 2'd1;
              cnt2_n  = 2'd0;
              state_n = S_NUM1;
            end else if (!(is_op || is_eq)) begin
              err_n = 1'b1;
            end
          end
          default: begin
            state_n = S_NUM1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Directed-vector bench for operand_collector with hand-computed expectations.
module tb_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [11:0] reg_num1, reg_num2;
  logic [7:0]  sym;
  logic [1:0]  cnt1, cnt2;
  logic        calc_start, err;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  operand_collector #(.DIGITS(3), .KEY_CLR(8'h78)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .reg_num1   (reg_num1),
    .reg_num2   (reg_num2),
    .sym        (sym),
    .cnt1       (cnt1),
    .cnt2       (cnt2),
    .calc_start (calc_start),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one key for a single cycle; returns on the following falling edge
  // with the key's effect visible on the registered outputs.
  task automatic press(input logic [7:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
  endtask

  task automatic idle();
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".state"}, 32'(state), 32'd0);
    check({tag, ".num1"},  32'(reg_num1), 32'h000);
    check({tag, ".num2"},  32'(reg_num2), 32'h000);
    check({tag, ".sym"},   32'(sym), 32'h00);
    check({tag, ".cnt1"},  32'(cnt1), 32'd0);
    check({tag, ".cnt2"},  32'(cnt2), 32'd0);
    check({tag, ".start"}, 32'(calc_start), 32'd0);
    check({tag, ".err"},   32'(err), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // 12 + 345 =
    press("1"); press("2"); press("a"); press("3"); press("4"); press("5");
    check("seq1.start_pre", 32'(calc_start), 32'd0);
    check("seq1.cnt2_pre",  32'(cnt2), 32'd3);
    press("e");
    check("seq1.start", 32'(calc_start), 32'd1);
    check("seq1.err",   32'(err), 32'd0);
    check("seq1.num1",  32'(reg_num1), 32'h012);
    check("seq1.sym",   32'(sym), 32'h61);
    check("seq1.num2",  32'(reg_num2), 32'h345);
    check("seq1.state", 32'(state), 32'd2);
    check("seq1.cnt1",  32'(cnt1), 32'd2);
    key_code = "7";
    idle();
    check("seq1.start_once", 32'(calc_start), 32'd0);
    check("seq1.hold_num1",  32'(reg_num1), 32'h012);
    press("b");
    check("done.op_err",   32'(err), 32'd0);
    check("done.op_state", 32'(state), 32'd2);
    check("done.op_sym",   32'(sym), 32'h61);

    // Digit in DONE starts a fresh expression
    press("3");
    check("done3.num1",  32'(reg_num1), 32'h003);
    check("done3.num2",  32'(reg_num2), 32'h000);
    check("done3.cnt1",  32'(cnt1), 32'd1);
    check("done3.cnt2",  32'(cnt2), 32'd0);
    check("done3.state", 32'(state), 32'd0);
    check("done3.sym",   32'(sym), 32'h61);

    // Digit overflow
    press("x");
    check_cleared("clr1");
    press("9"); press("8"); press("7");
    check("ovf.err_pre", 32'(err), 32'd0);
    press("6");
    check("ovf.err",  32'(err), 32'd1);
    check("ovf.num1", 32'(reg_num1), 32'h987);
    check("ovf.cnt1", 32'(cnt1), 32'd3);
    idle();
    check("ovf.err_once", 32'(err), 32'd0);

    // Divide by zero rejected, then clear
    press("x");
    press("7"); press("d"); press("0"); press("e");
    check("div0.err",   32'(err), 32'd1);
    check("div0.start", 32'(calc_start), 32'd0);
    check("div0.state", 32'(state), 32'd1);
    press("x");
    check_cleared("clr2");

    // Errors in NUM1, operator replacement in NUM2
    press("e");
    check("e_num1.err",   32'(err), 32'd1);
    check("e_num1.state", 32'(state), 32'd0);
    press("a");
    check("op_cnt0.err",   32'(err), 32'd1);
    check("op_cnt0.state", 32'(state), 32'd0);
    press("5"); press("a"); press("b");
    check("oprepl.err", 32'(err), 32'd0);
    check("oprepl.sym", 32'(sym), 32'h62);
    press("e");
    check("e_cnt2_0.err", 32'(err), 32'd1);
    check("e_cnt2_0.state", 32'(state), 32'd1);
    press("2"); press("c");
    check("op_late.err", 32'(err), 32'd1);
    check("op_late.sym", 32'(sym), 32'h62);
    press("z");
    check("badkey.err",   32'(err), 32'd1);
    check("badkey.state", 32'(state), 32'd1);
    check("badkey.num2",  32'(reg_num2), 32'h002);
    press("e");
    check("seq2.start", 32'(calc_start), 32'd1);
    check("seq2.err",   32'(err), 32'd0);
    check("seq2.sym",   32'(sym), 32'h62);
    check("seq2.num1",  32'(reg_num1), 32'h005);
    check("seq2.num2",  32'(reg_num2), 32'h002);

    // Reset with a key pending in NUM2
    press("x"); press("1"); press("a"); press("2");
    check("prerst.state", 32'(state), 32'd1);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = "e";
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    check_cleared("rstkey");
    idle();
    check("rstkey.start_after", 32'(calc_start), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter DIGITS, default 3: max BCD digits per operand (operand width = 4*DIGITS).
REQ-002 SHALL have parameter KEY_CLR, default 8'h78: ASCII 'x', the clear key.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port key_valid  in  1  key_code qualifier; one key consumed per cycle it is high.
REQ-006 SHALL have port key_code  in  8  ASCII key: '0'-'9' digit, 'a'/'b'/'c'/'d' = + - * /, 'e' = equals.
REQ-007 SHALL have port reg_num1  out  4*DIGITS  first operand, packed BCD, most significant digit highest.
REQ-008 SHALL have port reg_num2  out  4*DIGITS  second operand, packed BCD.
REQ-009 SHALL have port sym  out  8  operator ASCII code (8'h61-8'h64), consumed by the downstream calculate stage.
REQ-010 SHALL have port cnt1  out  2  digits entered in operand 1 (0..DIGITS).
REQ-011 SHALL have port cnt2  out  2  digits entered in operand 2 (0..DIGITS).
REQ-012 SHALL have port calc_start  out  1  one-cycle pulse: operands and sym are valid and complete.
REQ-013 SHALL have port err  out  1  one-cycle pulse: the key was rejected.
REQ-014 SHALL have port state  out  2  FSM state: 0 NUM1, 1 NUM2, 2 DONE.

Function
REQ-015 SHALL register all outputs; each accepted key updates them on the edge where key_valid=1 is sampled, which gives a latency of 1 cycle.
REQ-016 SHALL leave all outputs unchanged and keep calc_start/err low on any cycle with key_valid=0.
REQ-017 SHALL accept keys on consecutive cycles without loss; there is no backpressure.
REQ-018 SHALL, for a digit key in NUM1 with cnt1<DIGITS, shift it in as reg_num1 <= {reg_num1[4*DIGITS-5:0], key_code[3:0]} and increment cnt1.
REQ-019 SHALL, for a digit key in NUM1 with cnt1==DIGITS, ignore the digit and pulse err, leaving reg_num1 unchanged (no wrap-around).
REQ-020 SHALL, for an operator key in NUM1 with cnt1>=1, load sym and move to NUM2; with cnt1==0 it SHALL pulse err and stay in NUM1.
REQ-021 SHALL, in NUM2, apply the digit rules of REQ-018/REQ-019 to reg_num2/cnt2.
REQ-022 SHALL, for an operator key in NUM2 with cnt2==0, replace sym with no err; with cnt2>=1 it SHALL pulse err and leave sym unchanged.
REQ-023 SHALL, for 'e' in NUM2 with cnt2>=1, move to DONE and pulse calc_start, unless sym==8'h64 and reg_num2==0, in which case it SHALL pulse err and stay in NUM2.
REQ-024 SHALL, for 'e' in NUM1 or in NUM2 with cnt2==0, pulse err with no state change.
REQ-025 SHALL hold reg_num1, reg_num2, sym, cnt1 and cnt2 stable in DONE until the next accepted key.
REQ-026 SHALL, for a digit key in DONE, clear both operands and counts, load the digit as the first digit of reg_num1 (cnt1=1), keep sym, and move to NUM1.
REQ-027 SHALL, for 'e' or an operator key in DONE, ignore the key with no err.
REQ-028 SHALL, for KEY_CLR in any state, clear reg_num1, reg_num2, cnt1, cnt2 and sym to 0 and move to NUM1 with no err.
REQ-029 SHALL, for any other key_code in any state, pulse err with no other change.
REQ-030 SHALL never assert calc_start and err in the same cycle; calc_start SHALL pulse exactly once per completed expression.

Reset
REQ-031 SHALL, while rst=1 at an edge, set state=NUM1, reg_num1=0, reg_num2=0, sym=8'h00, cnt1=0, cnt2=0, calc_start=0, err=0.
REQ-032 SHALL give rst priority over a key_valid sampled on the same edge; that key is discarded.
REQ-033 SHALL, on reset during entry (NUM1, NUM2 or DONE), discard the partial expression with no calc_start pulse.

Verification
REQ-034 SHALL test keys '1','2','a','3','4','5','e' on consecutive cycles -> reg_num1=12'h012, sym=8'h61, reg_num2=12'h345, calc_start high exactly 1 cycle after 'e', state=DONE.
REQ-035 SHALL test keys '9','8','7','6' -> reg_num1=12'h987, cnt1=3, err pulse on the cycle after '6'.
REQ-036 SHALL test keys '7','d','0','e' -> err pulse after 'e', state stays NUM2, no calc_start; then 'x' -> all operands 0, state NUM1.
REQ-037 SHALL test keys 'e', then 'a' at cnt1=0 -> two err pulses, state NUM1; then '5','a','b','2','e' -> sym=8'h62, calc_start pulse.
REQ-038 SHALL test rst=1 asserted together with key_valid=1 in NUM2 -> all outputs at reset values next cycle, no calc_start.
REQ-039 SHALL test '3' in DONE after REQ-034 -> reg_num1=12'h003, reg_num2=0, cnt1=1, cnt2=0, state NUM1.
